// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: EX->MEM stage bus; master is the EX/MEM environment, slave is the stage register
interface ex_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [REG_AW-1:0] ex_wd, mem_wd;
    logic              ex_wreg, mem_wreg;
    logic [DATA_W-1:0] ex_wdata, mem_wdata;
    logic [6:0]        ex_opcode, mem_opcode;
    logic [2:0]        ex_funct3, mem_funct3;
    logic [DATA_W-1:0] ex_mem_addr, mem_mem_addr;
    logic [DATA_W-1:0] ex_mem_reg_data, mem_mem_reg_data;
    modport master (
        output in_valid, out_ready, ex_wd, ex_wreg, ex_wdata, ex_opcode, ex_funct3, ex_mem_addr, ex_mem_reg_data,
        input  in_ready, out_valid, mem_wd, mem_wreg, mem_wdata, mem_opcode, mem_funct3, mem_mem_addr, mem_mem_reg_data
    );
    modport slave (
        input  in_valid, out_ready, ex_wd, ex_wreg, ex_wdata, ex_opcode, ex_funct3, ex_mem_addr, ex_mem_reg_data,
        output in_ready, out_valid, mem_wd, mem_wreg, mem_wdata, mem_opcode, mem_funct3, mem_mem_addr, mem_mem_reg_data
    );
endinterface

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM stage register, legacy stall-vector mode or elastic 2-entry skid mode, with flush and bubble counter
module ex_mem_pipe #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 3,
    parameter int ELASTIC   = 0,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    ex_mem_pipe_if.slave       b,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   bubble_cnt
);
    typedef struct packed {
        logic [REG_AW-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] sdata;
    } pl_t;
    pl_t              main_q, main_d, skid_q, skid_d, pl_in;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
    logic             in_fire, out_fire, unused_stall;
    logic [CNT_W-1:0] bub_q;
    assign unused_stall = ^stall;
    assign pl_in = '{b.ex_wd, b.ex_wreg, b.ex_wdata, b.ex_opcode, b.ex_funct3, b.ex_mem_addr, b.ex_mem_reg_data};
    // rdy_q keeps in_ready low until the first edge after reset in both modes
    assign b.in_ready = rdy_q & ((ELASTIC != 0) | ~stall[STAGE_IDX]);
    assign in_fire = b.in_valid & b.in_ready;
    assign out_fire = main_v_q & b.out_ready;
    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        rdy_d    = 1'b1;
        if (flush) begin
            main_d   = '0;
            main_v_d = 1'b0;
            skid_d   = '0;
            skid_v_d = 1'b0;
        end else if (ELASTIC == 0) begin
            if (!stall[STAGE_IDX]) begin
                main_d   = in_fire ? pl_in : '0;
                main_v_d = in_fire;
            end else if (!stall[STAGE_IDX+1]) begin
                main_d   = '0;
                main_v_d = 1'b0;
            end
        end else begin
            // skid is only ever valid while in_ready is low, so it never competes with a new input
            if (!main_v_q || out_fire) begin
                main_d   = skid_v_q ? skid_q : (in_fire ? pl_in : '0);
                main_v_d = skid_v_q | in_fire;
                skid_d   = '0;
                skid_v_d = 1'b0;
            end else if (in_fire) begin
                skid_d   = pl_in;
                skid_v_d = 1'b1;
            end
            rdy_d = ~skid_v_d;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            rdy_q    <= 1'b0;
            bub_q    <= '0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            rdy_q    <= rdy_d;
            if (!main_v_q && !(&bub_q)) bub_q <= bub_q + 1'b1;
        end
    end
    assign b.out_valid = main_v_q;
    assign {b.mem_wd, b.mem_wreg, b.mem_wdata, b.mem_opcode, b.mem_funct3, b.mem_mem_addr, b.mem_mem_reg_data} = main_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign bubble_cnt = bub_q;
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: legacy and elastic instances checked every cycle against a queue-based behavioural model
module tb_ex_mem_pipe;
    localparam int DW = 32;
    localparam int AW = 5;
    typedef struct packed {
        logic [AW-1:0] wd;
        logic          wreg;
        logic [DW-1:0] wdata;
        logic [6:0]    opcode;
        logic [2:0]    funct3;
        logic [DW-1:0] addr;
        logic [DW-1:0] sdata;
    } pl_t;
    logic clk = 0, rst_n = 1, flush = 0, l_in_valid = 0, e_in_valid = 0, out_ready = 0;
    logic [5:0] stall = '0;
    logic [127:0] r;
    pl_t din = '0;
    pl_t l_out, e_out, lp = '0, ee;
    logic [1:0] l_occ, e_occ;
    logic [3:0] l_bub;
    logic [15:0] e_bub;
    int n_chk = 0, n_fail = 0, lbub = 0, ebub = 0;
    bit done = 0, lv = 0, lrdy = 0, erdy = 0, lfire, efire, eout;
    pl_t eq[$];
    ex_mem_pipe_if #(.DATA_W(DW), .REG_AW(AW)) li();
    ex_mem_pipe_if #(.DATA_W(DW), .REG_AW(AW)) ei();
    assign li.in_valid = l_in_valid;
    assign li.out_ready = out_ready;
    assign {li.ex_wd, li.ex_wreg, li.ex_wdata, li.ex_opcode, li.ex_funct3, li.ex_mem_addr, li.ex_mem_reg_data} = din;
    assign ei.in_valid = e_in_valid;
    assign ei.out_ready = out_ready;
    assign {ei.ex_wd, ei.ex_wreg, ei.ex_wdata, ei.ex_opcode, ei.ex_funct3, ei.ex_mem_addr, ei.ex_mem_reg_data} = din;
    assign l_out = {li.mem_wd, li.mem_wreg, li.mem_wdata, li.mem_opcode, li.mem_funct3, li.mem_mem_addr, li.mem_mem_reg_data};
    assign e_out = {ei.mem_wd, ei.mem_wreg, ei.mem_wdata, ei.mem_opcode, ei.mem_funct3, ei.mem_mem_addr, ei.mem_mem_reg_data};
    ex_mem_pipe #(.ELASTIC(0), .CNT_W(4)) u_leg (
        .clk(clk), .rst(rst_n), .stall(stall), .flush(flush), .b(li), .occupancy(l_occ), .bubble_cnt(l_bub));
    ex_mem_pipe #(.ELASTIC(1), .CNT_W(16)) u_ela (
        .clk(clk), .rst(rst_n), .stall(stall), .flush(flush), .b(ei), .occupancy(e_occ), .bubble_cnt(e_bub));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // reference: legacy is a single slot driven by stall rules, elastic is a FIFO of depth 2
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp = '0; lv = 0; lrdy = 0; lbub = 0;
            eq.delete(); erdy = 0; ebub = 0;
        end else begin
            lfire = l_in_valid && lrdy && !stall[3];
            efire = e_in_valid && erdy;
            eout  = eq.size() > 0 && out_ready;
            if (!lv) lbub = (lbub == 15) ? 15 : lbub + 1;
            if (eq.size() == 0) ebub = (ebub == 65535) ? 65535 : ebub + 1;
            if (flush) begin lv = 0; lp = '0; end
            else if (!stall[3]) begin lv = lfire; lp = lfire ? din : '0; end
            else if (!stall[4]) begin lv = 0; lp = '0; end
            if (flush) eq.delete();
            else begin
                if (eout) void'(eq.pop_front());
                if (efire) eq.push_back(din);
            end
            erdy = eq.size() < 2;
            lrdy = 1;
        end
    end
    always @(negedge clk) begin
        if (!done) begin
            ee = (eq.size() > 0) ? eq[0] : '0;
            chk("l_out_valid", li.out_valid, lv);
            chk("l_in_ready", li.in_ready, lrdy & ~stall[3]);
            chk("l_payload", l_out, lp);
            chk("l_occupancy", l_occ, lv);
            chk("l_bubble_cnt", l_bub, lbub);
            chk("e_out_valid", ei.out_valid, eq.size() != 0);
            chk("e_in_ready", ei.in_ready, erdy);
            chk("e_payload", e_out, ee);
            chk("e_occupancy", e_occ, eq.size());
            chk("e_bubble_cnt", e_bub, ebub);
        end
    end
    initial begin
        #1 rst_n = 0;
        repeat (3) step();
        chk("rst_l_valid", li.out_valid, 0);
        chk("rst_e_ready", ei.in_ready, 0);
        chk("rst_e_bub", e_bub, 0);
        rst_n = 1;
        step();
        chk("rel_e_ready", ei.in_ready, 1);
        chk("rel_bub1", e_bub, 1);
        step();
        step();
        chk("rel_bub3", e_bub, 3);
        stall = '0; l_in_valid = 1; din.wd = 5; din.wreg = 1; din.wdata = 32'hDEADBEEF;
        step();
        chk("leg_wd", li.mem_wd, 5);
        chk("leg_wdata", li.mem_wdata, 32'hDEADBEEF);
        chk("leg_valid", li.out_valid, 1);
        stall = 6'b001000; din.wd = 7;
        step();
        chk("leg_bubble_valid", li.out_valid, 0);
        chk("leg_bubble_payload", l_out, 0);
        stall = '0; din.wd = 9; din.wdata = 32'h1234;
        step();
        stall = 6'b011000; din.wd = 3; din.wdata = 32'h55;
        repeat (3) begin
            step();
            chk("leg_hold_wd", li.mem_wd, 9);
            chk("leg_hold_wdata", li.mem_wdata, 32'h1234);
        end
        stall = '0; l_in_valid = 0;
        step();
        out_ready = 0; e_in_valid = 1; din.wdata = 32'hA0A0A0A0;
        step();
        din.wdata = 32'hB0B0B0B0;
        step();
        e_in_valid = 0;
        chk("skid_occ2", e_occ, 2);
        chk("skid_ready0", ei.in_ready, 0);
        chk("skid_mainA", ei.mem_wdata, 32'hA0A0A0A0);
        out_ready = 1;
        step();
        chk("skid_mainB", ei.mem_wdata, 32'hB0B0B0B0);
        chk("skid_ready1", ei.in_ready, 1);
        step();
        chk("skid_drained", ei.out_valid, 0);
        out_ready = 0; e_in_valid = 1; din.wdata = 32'hA1;
        step();
        din.wdata = 32'hB1;
        step();
        chk("flush_pre_occ", e_occ, 2);
        din.wdata = 32'hC1; flush = 1;
        step();
        flush = 0; e_in_valid = 0;
        chk("flush_occ", e_occ, 0);
        chk("flush_valid", ei.out_valid, 0);
        chk("flush_payload", e_out, 0);
        out_ready = 1;
        repeat (3) step();
        out_ready = 0; e_in_valid = 1; din.wdata = 32'hA2;
        step();
        din.wdata = 32'hB2;
        step();
        e_in_valid = 0;
        chk("arst_pre_occ", e_occ, 2);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_occ", e_occ, 0);
        chk("arst_valid", ei.out_valid, 0);
        chk("arst_payload", e_out, 0);
        chk("arst_bub", e_bub, 0);
        @(posedge clk);
        #1 rst_n = 1;
        step();
        chk("arst_bub1", e_bub, 1);
        step();
        chk("arst_bub2", e_bub, 2);
        step();
        chk("arst_bub3", e_bub, 3);
        repeat (20) step();
        chk("sat_bub", l_bub, 15);
        flush = 1;
        step();
        flush = 0;
        chk("sat_flush_bub", l_bub, 15);
        repeat (3000) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            din = r[111:0];
            l_in_valid = $urandom_range(0, 3) != 0;
            e_in_valid = $urandom_range(0, 1) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            stall = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
            flush = $urandom_range(0, 31) == 0;
            step();
        end
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Parametrised EX→MEM stage register, successor to the fixed-width stall-only stage register.
- Carries register-writeback and memory-access fields from EX to MEM.
- Two modes: legacy stall-vector mode (bubble/hold semantics) and elastic mode (valid/ready handshake with a 2-entry skid buffer).
- Adds synchronous flush and a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 32, width of wdata, mem_addr, mem_reg_data
- REG_AW, 5, destination register index width
- STALL_W, 6, stall vector width
- STAGE_IDX, 3, stall bit owned by this stage; STAGE_IDX+1 must be < STALL_W
- ELASTIC, 0, 0 = legacy stall-vector mode, 1 = valid/ready skid-buffer mode
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  STALL_W  pipeline stall vector; used only when ELASTIC=0
- flush  in  1  synchronous kill of all held contents
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage accepts input this cycle
- ex_wd  in  REG_AW  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  DATA_W  writeback data
- ex_opcode  in  7  opcode
- ex_funct3  in  3  funct3
- ex_mem_addr  in  DATA_W  memory address
- ex_mem_reg_data  in  DATA_W  store data
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM accepts; ignored when ELASTIC=0
- mem_wd, mem_wreg, mem_wdata, mem_opcode, mem_funct3, mem_mem_addr, mem_mem_reg_data  out  widths as inputs  registered payload
- occupancy  out  2  entries held (0..2; max 1 when ELASTIC=0)
- bubble_cnt  out  CNT_W  cycles with out_valid=0 since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - all payload outputs, out_valid, occupancy, bubble_cnt = 0
  - skid entry invalid and zeroed
  - in_ready = 0 while in reset, 1 on the first cycle after release
- Payload rule: whenever out_valid=0, all payload outputs read zero (bubble = all-zero payload). mem_wreg is never 1 with out_valid=0.
- Flush: highest priority after reset.
  - Next edge clears main and skid entries, zeroes payload, out_valid=0.
  - An input presented in the flush cycle is discarded even if in_ready=1.
- ELASTIC=0 (legacy), priority order:
  - flush
  - stall[S]=1 and stall[S+1]=0: load bubble
  - stall[S]=1 and stall[S+1]=1: hold all outputs
  - stall[S]=0: load ex_* fields, out_valid <= in_valid
- ELASTIC=0 handshake signals:
  - in_ready = ~stall[S] (combinational)
  - occupancy = out_valid
- ELASTIC=1 (skid): main entry drives outputs; skid entry holds overflow.
  - in_ready is a registered signal = ~skid_valid.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - main empty, in_fire: load main.
  - main full, out_fire, no in_fire: main <= skid if skid valid, else empty.
  - main full, out_fire and in_fire, skid empty: main <= input.
  - main full, no out_fire, in_fire: skid <= input; in_ready drops next cycle.
  - skid full, out_fire: main <= skid, skid empty, in_ready rises next cycle.
  - Order is preserved; no entry is lost or duplicated; latency 1 cycle when unblocked.
- bubble_cnt: increments each cycle out_valid=0 (not in reset), saturates at 2^CNT_W−1. Cleared only by reset, not by flush.
- stall is ignored in ELASTIC=1; out_ready is ignored in ELASTIC=0.

Test Plan:
- ELASTIC=0, stall=0, in_valid=1, ex_wd=5, ex_wdata=0xDEADBEEF -> next edge mem_wd=5, mem_wdata=0xDEADBEEF, out_valid=1.
- ELASTIC=0, stall=6'b001000 -> all outputs 0, out_valid=0; stall=6'b011000 -> outputs hold prior values for every stalled cycle.
- ELASTIC=1, out_ready=0, push A then B -> occupancy=2, in_ready=0, mem_wdata=A; raise out_ready -> A then B emerge on consecutive cycles, in_ready=1 after B moves to main.
- ELASTIC=1, occupancy=2, flush=1 with in_valid=1 carrying C -> next edge occupancy=0, out_valid=0, payload 0, C never appears.
- Assert rst=0 mid-transfer (occupancy=2), asynchronous to clk -> outputs 0 immediately; bubble_cnt counts 1,2,3… after release with no input.
- CNT_W=4, idle for 20 cycles -> bubble_cnt saturates at 15; flush leaves it at 15.
